// File: rtl/spi_frame_writer_pkg.sv
// Shared constants, FSM state type and pixel helper for the SPI frame writer.
// No ports; imported by the frame-writer RTL and its bench.
package spi_frame_writer_pkg;

    // Host opcodes
    localparam logic [7:0] CMD_WRITE = 8'h01;
    localparam logic [7:0] CMD_FILL  = 8'h02;

    // Frame-buffer geometry: addr = col + row * FB_COLS
    localparam int unsigned FB_ADDR_W = 13;
    localparam int unsigned FB_DATA_W = 16;
    localparam int unsigned FB_COLS   = 256;
    localparam int unsigned FB_ROWS   = 32;

    // RGB555 field offsets inside a pixel word
    localparam int unsigned RGB_R_OFS = 0;
    localparam int unsigned RGB_G_OFS = 5;
    localparam int unsigned RGB_B_OFS = 10;

    // Each state names the byte the FSM is waiting for
    typedef enum logic [3:0] {
        S_IDLE,
        S_CMD,
        S_AHI,
        S_ALO,
        S_PHI,
        S_PLO,
        S_CHI,
        S_CLO,
        S_RUN,
        S_DISCARD
    } state_t;

    function automatic logic [15:0] rgb555(input logic [4:0] r, input logic [4:0] g,
                                           input logic [4:0] b);
        return (16'(r) << RGB_R_OFS) | (16'(g) << RGB_G_OFS) | (16'(b) << RGB_B_OFS);
    endfunction

endpackage

// File: rtl/spi_frame_writer_byte_rx.sv
// SPI mode-0 byte receiver: synchronises sck/mosi/cs_n, detects edges and
// assembles MSB-first bytes.
// Ports: clk, rst (async high); spi_sck/spi_mosi/spi_cs_n raw inputs;
// byte_valid + rx_byte one-cycle byte strobe; cs_fall/cs_rise one-cycle
// strobes aligned to the same pipeline depth as byte_valid.
module spi_frame_writer_byte_rx #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spi_sck,
    input  logic       spi_mosi,
    input  logic       spi_cs_n,
    output logic       byte_valid,
    output logic [7:0] rx_byte,
    output logic       cs_fall,
    output logic       cs_rise
);

    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic                   sck_prev;
    logic                   cs_prev;
    logic                   sck_rise_r;
    logic                   cs_fall_r;
    logic                   cs_rise_r;
    logic                   mosi_r;
    logic                   in_frame;
    logic [2:0]             bit_cnt;
    logic [6:0]             shift;

    // cs_n synchronisers reset high so release of rst never looks like a cs fall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_sync   <= '0;
            mosi_sync  <= '0;
            cs_sync    <= '1;
            sck_prev   <= 1'b0;
            cs_prev    <= 1'b1;
            sck_rise_r <= 1'b0;
            cs_fall_r  <= 1'b0;
            cs_rise_r  <= 1'b0;
            mosi_r     <= 1'b0;
            in_frame   <= 1'b0;
            bit_cnt    <= 3'd0;
            shift      <= 7'd0;
            byte_valid <= 1'b0;
            rx_byte    <= 8'd0;
            cs_fall    <= 1'b0;
            cs_rise    <= 1'b0;
        end else begin
            sck_sync  <= (sck_sync << 1) | SYNC_STAGES'(spi_sck);
            mosi_sync <= (mosi_sync << 1) | SYNC_STAGES'(spi_mosi);
            cs_sync   <= (cs_sync << 1) | SYNC_STAGES'(spi_cs_n);

            // Edge strobes from the last synchroniser stage, registered
            sck_prev   <= sck_sync[SYNC_STAGES-1];
            cs_prev    <= cs_sync[SYNC_STAGES-1];
            sck_rise_r <= sck_sync[SYNC_STAGES-1] & ~sck_prev;
            cs_fall_r  <= cs_prev & ~cs_sync[SYNC_STAGES-1];
            cs_rise_r  <= ~cs_prev & cs_sync[SYNC_STAGES-1];
            mosi_r     <= mosi_sync[SYNC_STAGES-1];

            byte_valid <= 1'b0;
            cs_fall    <= cs_fall_r;
            cs_rise    <= cs_rise_r;

            // A cs edge restarts bit counting; a partial byte at cs rise is dropped
            if (cs_fall_r) begin
                in_frame <= 1'b1;
                bit_cnt  <= 3'd0;
            end else if (cs_rise_r) begin
                in_frame <= 1'b0;
                bit_cnt  <= 3'd0;
            end else if (sck_rise_r && in_frame) begin
                shift   <= {shift[5:0], mosi_r};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    byte_valid <= 1'b1;
                    rx_byte    <= {shift, mosi_r};
                end
            end
        end
    end

endmodule

// File: rtl/spi_frame_writer.sv
// SPI slave that writes RGB555 pixels into the frame RAM write port.
// Commands: 0x01 WRITE (addr, then pixel pairs), 0x02 FILL (addr, pixel, count).
// Ports: clk, rst (async high); spi_sck/spi_mosi/spi_cs_n from the host;
// wr_en/wr_addr/wr_data RAM write port; busy while a FILL runs;
// frame_done pulse per transaction that wrote; overrun sticky flag.
module spi_frame_writer
    import spi_frame_writer_pkg::*;
#(
    parameter int unsigned ADDR_W      = FB_ADDR_W,
    parameter int unsigned DATA_W      = FB_DATA_W,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_sck,
    input  logic              spi_mosi,
    input  logic              spi_cs_n,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              frame_done,
    output logic              overrun
);

    logic              byte_valid;
    logic [7:0]        rx_byte;
    logic              cs_fall;
    logic              cs_rise;

    state_t            state;
    logic [7:0]        opcode;
    logic [4:0]        addr_hi;
    logic [7:0]        pix_hi;
    logic [7:0]        cnt_hi;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] pixel;
    logic [15:0]       remaining;
    logic              wrote;
    logic              fill_cs_rose;
    logic              cs_low;

    logic              cs_low_next;
    logic              write_now;
    logic [15:0]       clo_count;
    logic              run_start;

    spi_frame_writer_byte_rx #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_rx (
        .clk       (clk),
        .rst       (rst),
        .spi_sck   (spi_sck),
        .spi_mosi  (spi_mosi),
        .spi_cs_n  (spi_cs_n),
        .byte_valid(byte_valid),
        .rx_byte   (rx_byte),
        .cs_fall   (cs_fall),
        .cs_rise   (cs_rise)
    );

    // Decode helpers for the same-cycle byte/cs-rise cases
    assign cs_low_next = cs_fall ? 1'b1 : (cs_rise ? 1'b0 : cs_low);
    assign write_now   = byte_valid && (state == S_PLO) && (opcode == CMD_WRITE);
    assign clo_count   = {cnt_hi, rx_byte};
    assign run_start   = byte_valid && (state == S_CLO) && (clo_count != 16'd0);

    // Command FSM, address/count counters and registered write port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            opcode       <= 8'd0;
            addr_hi      <= 5'd0;
            pix_hi       <= 8'd0;
            cnt_hi       <= 8'd0;
            addr         <= '0;
            pixel        <= '0;
            remaining    <= 16'd0;
            wrote        <= 1'b0;
            fill_cs_rose <= 1'b0;
            cs_low       <= 1'b0;
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            wr_en      <= 1'b0;
            frame_done <= 1'b0;
            cs_low     <= cs_low_next;
            if (cs_fall && busy) begin
                overrun <= 1'b1;
            end

            if (state == S_RUN) begin
                // FILL owns the port; cs edges and bytes only get bookkept here
                if (cs_rise) begin
                    fill_cs_rose <= 1'b1;
                end
                if (remaining == 16'd0) begin
                    busy <= 1'b0;
                    if (fill_cs_rose || cs_rise) begin
                        frame_done <= 1'b1;
                        wrote      <= 1'b0;
                        // cs still low here means a new transaction started mid-fill
                        state      <= cs_low_next ? S_DISCARD : S_IDLE;
                    end else begin
                        wrote <= 1'b1;
                        state <= S_DISCARD;
                    end
                end else begin
                    wr_en     <= 1'b1;
                    wr_addr   <= addr;
                    wr_data   <= pixel;
                    addr      <= addr + ADDR_W'(1);
                    remaining <= remaining - 16'd1;
                end
            end else begin
                if (byte_valid) begin
                    case (state)
                        S_CMD: begin
                            opcode <= rx_byte;
                            state  <= (rx_byte == CMD_WRITE || rx_byte == CMD_FILL) ?
                                      S_AHI : S_DISCARD;
                        end
                        S_AHI: begin
                            addr_hi <= rx_byte[4:0];
                            state   <= S_ALO;
                        end
                        S_ALO: begin
                            addr  <= ADDR_W'({addr_hi, rx_byte});
                            state <= S_PHI;
                        end
                        S_PHI: begin
                            pix_hi <= rx_byte;
                            state  <= S_PLO;
                        end
                        S_PLO: begin
                            pixel <= DATA_W'({pix_hi, rx_byte});
                            if (opcode == CMD_WRITE) begin
                                wr_en   <= 1'b1;
                                wr_addr <= addr;
                                wr_data <= DATA_W'({pix_hi, rx_byte});
                                addr    <= addr + ADDR_W'(1);
                                wrote   <= 1'b1;
                                state   <= S_PHI;
                            end else begin
                                state <= S_CHI;
                            end
                        end
                        S_CHI: begin
                            cnt_hi <= rx_byte;
                            state  <= S_CLO;
                        end
                        S_CLO: begin
                            // First fill write issues in the same cycle busy rises
                            if (clo_count != 16'd0) begin
                                busy         <= 1'b1;
                                wr_en        <= 1'b1;
                                wr_addr      <= addr;
                                wr_data      <= pixel;
                                addr         <= addr + ADDR_W'(1);
                                remaining    <= clo_count - 16'd1;
                                fill_cs_rose <= cs_rise;
                                state        <= S_RUN;
                            end else begin
                                state <= S_DISCARD;
                            end
                        end
                        default: ;
                    endcase
                end

                // cs edges override the byte-driven next state, except a fill start
                if (cs_fall) begin
                    state <= S_CMD;
                    wrote <= 1'b0;
                end else if (cs_rise && !run_start) begin
                    state      <= S_IDLE;
                    frame_done <= wrote || write_now;
                    wrote      <= 1'b0;
                end
            end
        end
    end

endmodule
